// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial values to an external comparator.
// Optional define SAR_FLAG_REG_EN registers the comparator flags, adding a WAIT state per probe.
module sar_search_ctrl #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_GT,
   input  logic             i_LT,
   input  logic             i_EQ,
   output logic [WIDTH-1:0] o_guess,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_result,
   output logic             o_err
);

   localparam int unsigned KW = $clog2(WIDTH);

`ifdef SAR_FLAG_REG_EN
   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_WAIT, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;
`endif

   state_t           state;
   logic [KW-1:0]    k;
   logic             f_gt, f_lt, f_eq;
   logic [WIDTH-1:0] step_mask, next_mask, guess_gt, guess_lt;
   logic             k_zero, flags_bad;

`ifdef SAR_FLAG_REG_EN
   logic [2:0] flags_q;
   assign {f_gt, f_lt, f_eq} = flags_q;
`else
   assign {f_gt, f_lt, f_eq} = {i_GT, i_LT, i_EQ};
`endif

   // Bit k is the bit under trial; all lower guess bits are still zero.
   always_comb begin
      step_mask = WIDTH'(1) << k;
      next_mask = step_mask >> 1;
      guess_gt  = o_guess | next_mask;
      guess_lt  = (o_guess & ~step_mask) | next_mask;
      k_zero    = (k == '0);
      flags_bad = ~((f_gt ^ f_lt ^ f_eq) & ~(f_gt & f_lt & f_eq));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         k        <= '0;
         o_guess  <= '0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_valid  <= 1'b0;
         o_result <= '0;
         o_err    <= 1'b0;
`ifdef SAR_FLAG_REG_EN
         flags_q  <= '0;
`endif
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  state    <= S_PROBE;
                  o_busy   <= 1'b1;
                  o_valid  <= 1'b0;
                  o_err    <= 1'b0;
                  o_result <= '0;
                  o_guess  <= {1'b1, {(WIDTH-1){1'b0}}};
                  k        <= KW'(WIDTH - 1);
               end else begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            end
            // With registered flags, PROBE only captures them and WAIT runs the shared decision.
`ifdef SAR_FLAG_REG_EN
            S_PROBE: begin
               flags_q <= {i_GT, i_LT, i_EQ};
               state   <= S_WAIT;
            end
            S_WAIT: begin
`else
            S_PROBE: begin
`endif
               if (flags_bad || (f_gt && k_zero)) begin
                  o_err   <= 1'b1;
                  o_valid <= 1'b0;
                  o_done  <= 1'b1;
                  o_busy  <= 1'b0;
                  state   <= S_DONE;
               end else if (f_eq) begin
                  o_result <= o_guess;
                  o_valid  <= 1'b1;
                  o_done   <= 1'b1;
                  o_busy   <= 1'b0;
                  state    <= S_DONE;
               end else if (k_zero) begin
                  o_result <= {o_guess[WIDTH-1:1], 1'b0};
                  o_valid  <= 1'b1;
                  o_done   <= 1'b1;
                  o_busy   <= 1'b0;
                  state    <= S_DONE;
               end else begin
                  o_guess <= f_gt ? guess_gt : guess_lt;
                  k       <= k - KW'(1);
                  state   <= S_PROBE;
               end
            end
            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl: WIDTH=2 and WIDTH=4 instances on a behavioural comparator.
module tb_sar_search_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sel4;
   logic [3:0] unknown;
   int         fmode;
   logic       gt, lt, eq;

   logic [1:0] guess2, result2;
   logic       busy2, done2, valid2, err2;
   logic [3:0] guess4, result4;
   logic       busy4, done4, valid4, err4;

   int guess_s, result_s;
   logic busy_s, done_s, valid_s, err_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sar_search_ctrl #(.WIDTH(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start & ~sel4),
      .i_GT(gt), .i_LT(lt), .i_EQ(eq),
      .o_guess(guess2), .o_busy(busy2), .o_done(done2),
      .o_valid(valid2), .o_result(result2), .o_err(err2)
   );

   sar_search_ctrl #(.WIDTH(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start & sel4),
      .i_GT(gt), .i_LT(lt), .i_EQ(eq),
      .o_guess(guess4), .o_busy(busy4), .o_done(done4),
      .o_valid(valid4), .o_result(result4), .o_err(err4)
   );

   // Comparator model on the selected instance; fmode injects faulty flag patterns.
   always_comb begin
      guess_s  = sel4 ? int'(guess4) : int'(guess2);
      result_s = sel4 ? int'(result4) : int'(result2);
      busy_s   = sel4 ? busy4 : busy2;
      done_s   = sel4 ? done4 : done2;
      valid_s  = sel4 ? valid4 : valid2;
      err_s    = sel4 ? err4 : err2;
      gt = int'(unknown) > guess_s;
      lt = int'(unknown) < guess_s;
      eq = int'(unknown) == guess_s;
      case (fmode)
         1: {gt, lt, eq} = 3'b110;
         2: if (guess_s == 1) {gt, lt, eq} = 3'b100;
         3: {gt, lt, eq} = 3'b000;
         default: ;
      endcase
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Probes needed: search stops at the lowest set bit of the unknown, or runs all bits for zero.
   function automatic int exp_probes(input int w, input int u);
      if (u == 0) return w;
      for (int p = 0; p < w; p++)
         if (((u >> p) & 1) == 1) return w - p;
      return w;
   endfunction

   function automatic int exp_edges(input int n);
`ifdef SAR_FLAG_REG_EN
      return 2 * n + 1;
`else
      return n + 1;
`endif
   endfunction

   task automatic run(input int unk, input int fm, input bit is4, output int edges);
      int w;
      w       = is4 ? 4 : 2;
      sel4    = is4;
      unknown = 4'(unk);
      fmode   = fm;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 1;
      chk("busy_after_start", int'(busy_s), 1);
      chk("err_cleared_on_start", int'(err_s), 0);
      chk("valid_cleared_on_start", int'(valid_s), 0);
      chk("first_guess", guess_s, 1 << (w - 1));
      while (!done_s && edges < 64) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("done_seen", int'(done_s), 1);
   endtask

   task automatic run_good(input int unk, input bit is4);
      int e, w;
      w = is4 ? 4 : 2;
      run(unk, 0, is4, e);
      chk("result", result_s, unk);
      chk("valid", int'(valid_s), 1);
      chk("err", int'(err_s), 0);
      chk("latency", e, exp_edges(exp_probes(w, unk)));
      chk("latency_bound", int'(e <= exp_edges(w)), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      rst_n = 1'b0; start = 1'b0; sel4 = 1'b0; fmode = 0; unknown = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_guess2", int'(guess2), 0);
      chk("rst_busy2", int'(busy2), 0);
      chk("rst_done2", int'(done2), 0);
      chk("rst_valid2", int'(valid2), 0);
      chk("rst_result2", int'(result2), 0);
      chk("rst_err2", int'(err2), 0);
      chk("rst_guess4", int'(guess4), 0);
      chk("rst_done4", int'(done4), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // T1..T3 on the 2-bit instance, then done-pulse and hold behaviour.
      run_good(2, 1'b0);
      @(posedge clk); #1;
      chk("done_one_cycle", int'(done_s), 0);
      chk("idle_not_busy", int'(busy_s), 0);
      chk("result_held", result_s, 2);
      chk("valid_held", int'(valid_s), 1);
      chk("guess_held", guess_s, 2);
      run_good(3, 1'b0);
      @(posedge clk); #1;
      run_good(0, 1'b0);
      @(posedge clk); #1;

      // T4: inconsistent flag patterns.
      run(1, 1, 1'b0, e);
      chk("both_flags_err", int'(err_s), 1);
      chk("both_flags_valid", int'(valid_s), 0);
      chk("both_flags_result", result_s, 0);
      chk("both_flags_latency", e, exp_edges(1));
      @(posedge clk); #1;
      chk("err_sticky", int'(err_s), 1);
      run(2, 3, 1'b0, e);
      chk("no_flags_err", int'(err_s), 1);
      chk("no_flags_valid", int'(valid_s), 0);
      run_good(2, 1'b0);
      @(posedge clk); #1;
      run(1, 2, 1'b0, e);
      chk("gt_k0_err", int'(err_s), 1);
      chk("gt_k0_valid", int'(valid_s), 0);
      chk("gt_k0_latency", e, exp_edges(2));
      run_good(1, 1'b0);
      @(posedge clk); #1;

      // T5: start while busy is ignored, reset mid-search aborts without done.
      sel4 = 1'b0; unknown = 4'd3; fmode = 0; start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
`ifdef SAR_FLAG_REG_EN
      chk("busy_start_ignored_guess", guess_s, 2);
`else
      chk("busy_start_ignored_guess", guess_s, 3);
`endif
      chk("busy_start_still_busy", int'(busy_s), 1);
      chk("busy_start_no_done", int'(done_s), 0);
      start = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_guess", guess_s, 0);
      chk("midrst_busy", int'(busy_s), 0);
      chk("midrst_done", int'(done_s), 0);
      chk("midrst_valid", int'(valid_s), 0);
      chk("midrst_result", result_s, 0);
      chk("midrst_err", int'(err_s), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_done", int'(done_s), 0);
      chk("postrst_busy", int'(busy_s), 0);

      // T6: full 4-bit sweep with back-to-back starts accepted in DONE.
      for (int u = 0; u < 16; u++) run_good(u, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 24; i++) begin
         bit is4;
         is4 = 1'($urandom_range(0, 1));
         run_good(int'($urandom_range(0, is4 ? 15 : 3)), is4);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
